// File: rtl/task_pkg.sv
// rtl/task_pkg.sv - shared opcode fields, dest codes, FSM states and task entry type
package task_pkg;

    localparam int OP_W    = 5;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = OP_W + DATA_W;

    // Opcode layout: {trans_id[4:3], dest[2:1], rw[0]}
    localparam int OP_RW_BIT   = 0;
    localparam int OP_DEST_LSB = 1;
    localparam int OP_DEST_MSB = 2;
    localparam int OP_TID_LSB  = 3;
    localparam int OP_TID_MSB  = 4;

    localparam logic [1:0] DEST_IO  = 2'd0;
    localparam logic [1:0] DEST_ALU = 2'd1;
    localparam logic [1:0] DEST_MEM = 2'd2;
    localparam logic [1:0] DEST_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] wdata;
    } task_t;

    function automatic logic [1:0] op_dest(input logic [OP_W-1:0] op);
        return op[OP_DEST_MSB:OP_DEST_LSB];
    endfunction

    function automatic logic [1:0] op_tid(input logic [OP_W-1:0] op);
        return op[OP_TID_MSB:OP_TID_LSB];
    endfunction

    function automatic logic op_rw(input logic [OP_W-1:0] op);
        return op[OP_RW_BIT];
    endfunction

endpackage

// File: rtl/task_fifo_mem.sv
// rtl/task_fifo_mem.sv - DEPTH x 13-bit task storage, one write port, async read port
module task_fifo_mem
    import task_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Entry contents need no reset: the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/task_dispatcher.sv
// rtl/task_dispatcher.sv - task queue feeding a controller; TASK_DISPATCHER_STATS_EN adds per-dest pop counters
module task_dispatcher
    import task_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        in_valid,
    input  logic [4:0]  in_opcode,
    input  logic [7:0]  in_wdata,
    output logic        in_ready,
    input  logic        READY,
    output logic [4:0]  OPCODE,
    output logic [7:0]  WDATA,
    output logic        out_valid,
    output logic [7:0]  task_num,
    output logic [4:0]  level,
    output logic        err_dest
`ifdef TASK_DISPATCHER_STATS_EN
    ,
    output logic [7:0]  io_cnt,
    output logic [7:0]  alu_cnt,
    output logic [7:0]  mem_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] LVL_FULL = 5'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         level_nxt;
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [ENTRY_W-1:0] head_entry;
    task_t              head_task;
    logic               push;
    logic               pop;
    logic               bad;

    assign in_ready = (state != ST_FULL);
    assign pop      = out_valid & READY;
    assign push     = in_valid & in_ready & (op_dest(in_opcode) != DEST_BAD);
    assign bad      = in_valid & in_ready & (op_dest(in_opcode) == DEST_BAD);

    task_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata ({in_opcode, in_wdata}),
        .raddr (head),
        .rdata (head_entry)
    );

    // Show-ahead head entry, forced to zero while nothing is queued
    assign head_task = head_entry;
    assign OPCODE    = out_valid ? head_task.opcode : '0;
    assign WDATA     = out_valid ? head_task.wdata  : '0;

    // Next occupancy and the state it implies
    always_comb begin
        level_nxt = level + {4'd0, push} - {4'd0, pop};
        state_nxt = ST_ACTIVE;
        if (level_nxt == 5'd0) begin
            state_nxt = ST_EMPTY;
        end else if (level_nxt == LVL_FULL) begin
            state_nxt = ST_FULL;
        end
    end

    // Queue FSM, pointers, consumed-task counter and sticky dest error
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state     <= ST_EMPTY;
            level     <= 5'd0;
            out_valid <= 1'b0;
            head      <= '0;
            tail      <= '0;
            task_num  <= 8'd0;
            err_dest  <= 1'b0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            out_valid <= (state_nxt != ST_EMPTY);
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head     <= head + 1'b1;
                task_num <= task_num + 8'd1;
            end
            if (bad) begin
                err_dest <= 1'b1;
            end
        end
    end

`ifdef TASK_DISPATCHER_STATS_EN
    // Per-destination pop counters, keyed on the entry leaving the queue
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            io_cnt  <= 8'd0;
            alu_cnt <= 8'd0;
            mem_cnt <= 8'd0;
        end else if (pop) begin
            case (op_dest(head_task.opcode))
                DEST_IO:  io_cnt  <= io_cnt  + 8'd1;
                DEST_ALU: alu_cnt <= alu_cnt + 8'd1;
                DEST_MEM: mem_cnt <= mem_cnt + 8'd1;
                default:  ;
            endcase
        end
    end
`endif

endmodule
